// File: rtl/write_ram_mem.sv
// write_ram_mem
//   Sequential RAM writer. A start request takes a snapshot of a local DEP x WID word array
//   and then writes num_words of those words (clamped to DEP) to an external single-port RAM
//   at addresses 0..count-1. Each word takes three cycles: SETUP, WRITE, INC.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   start         level request, accepted only in IDLE
//   num_words     number of words to write, sampled when start is accepted
//   wr_data_in    local word array, copied into the snapshot when start is accepted
//   address       RAM address
//   ram_data_out  RAM write data
//   wren          RAM write enable, one-cycle pulse per word
//   busy          high from start accept until DONE is entered
//   done          high after the last word; stays high in IDLE until the next accept
module write_ram_mem #(
    parameter int unsigned DEP = 32,
    parameter int unsigned WID = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [8:0]     num_words,
    input  logic [WID-1:0] wr_data_in [DEP],
    output logic [8:0]     address,
    output logic [WID-1:0] ram_data_out,
    output logic           wren,
    output logic           busy,
    output logic           done
);

    localparam int unsigned IW    = (DEP > 1) ? $clog2(DEP) : 1;
    localparam logic [8:0]  DEP_W = 9'(DEP);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWrite,
        StInc,
        StDone
    } state_t;

    state_t         state;
    logic [WID-1:0] snap [DEP];
    logic [8:0]     index;
    logic [8:0]     count;
    logic [8:0]     count_in;
    logic [8:0]     index_nxt;
    logic           accept;

    always_comb begin
        count_in  = (num_words > DEP_W) ? DEP_W : num_words;
        index_nxt = index + 9'd1;
        accept    = (state == StIdle) && start;
    end

    // Snapshot storage needs no reset: it is only read after being loaded by an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            snap <= wr_data_in;
        end
    end

    // Address and data are registered one state ahead of wren so they are already stable
    // for the whole cycle in which wren is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            address      <= '0;
            ram_data_out <= '0;
            wren         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            index        <= '0;
            count        <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    wren <= 1'b0;
                    if (start) begin
                        count        <= count_in;
                        index        <= '0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        address      <= '0;
                        // Snapshot loads on this same edge, so take word 0 from the input.
                        ram_data_out <= wr_data_in[0];
                        state        <= (count_in == 9'd0) ? StDone : StSetup;
                    end
                end
                StSetup: begin
                    wren  <= 1'b1;
                    state <= StWrite;
                end
                StWrite: begin
                    wren  <= 1'b0;
                    state <= StInc;
                end
                StInc: begin
                    wren <= 1'b0;
                    if (index == count - 9'd1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else begin
                        index        <= index_nxt;
                        address      <= index_nxt;
                        ram_data_out <= snap[index_nxt[IW-1:0]];
                        state        <= StSetup;
                    end
                end
                StDone: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    wren <= 1'b0;
                    // Holding start high parks here so a single request cannot retrigger.
                    if (!start) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    wren  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_ram_mem.sv
module tb_write_ram_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] num_words;
    logic [7:0] wr_data_in [32];
    logic [8:0] address;
    logic [7:0] ram_data_out;
    logic       wren;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    logic prev_wren = 1'b0;
    logic [16:0] exp_q [$];

    write_ram_mem #(.DEP(32), .WID(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_words    (num_words),
        .wr_data_in   (wr_data_in),
        .address      (address),
        .ram_data_out (ram_data_out),
        .wren         (wren),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every wren pulse must match the head of the expected-write queue.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!reset) begin
            if (wren) begin
                if (prev_wren) begin
                    checks++;
                    errors++;
                    $display("FAIL wren_back_to_back: got 2 consecutive cycles expected 1");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                             address, ram_data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({address, ram_data_out} !== e) begin
                        errors++;
                        $display("FAIL write_word: got addr %0d data %0h expected addr %0d data %0h",
                                 address, ram_data_out, e[16:8], e[7:0]);
                    end
                end
                wr_seen++;
            end
            prev_wren = wren;
        end else begin
            prev_wren = 1'b0;
        end
    end

    // One run: fill the array, push expected writes, request, then time the run to done.
    task automatic run(input int nw, input logic [7:0] key, input bit snapchg, input bit hold);
        int n;
        int cyc;
        int seen0;
        n = (nw > 32) ? 32 : nw;
        for (int i = 0; i < 32; i++) wr_data_in[i] = 8'(i) ^ key;
        for (int i = 0; i < n; i++) exp_q.push_back({9'(i), 8'(i) ^ key});
        seen0 = wr_seen;
        num_words = 9'(nw);
        start = 1'b1;
        @(posedge clk);
        for (cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("busy_after_accept", 32'(busy), 32'd1);
                chk("done_cleared_on_accept", 32'(done), 32'd0);
                if (snapchg) begin
                    for (int i = 0; i < 32; i++) wr_data_in[i] = 8'hFF;
                    num_words = 9'd0;
                end
            end
            if (done) break;
        end
        chk("latency_to_done", 32'(cyc - 1), (n == 0) ? 32'd1 : 32'(3 * n));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("write_count", 32'(wr_seen - seen0), 32'(n));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int seen;
        bit hit;
        reset = 1'b1;
        start = 1'b0;
        num_words = '0;
        for (int i = 0; i < 32; i++) wr_data_in[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_address", 32'(address), 32'd0);
        chk("reset_wren", 32'(wren), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // Reset during the fifth write pulse.
        for (int i = 0; i < 32; i++) wr_data_in[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 5; i++) exp_q.push_back({9'(i), 8'(i) ^ 8'hA5});
        num_words = 9'd32;
        start = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #2;
            if (wren && wr_seen == 5) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_fifth_write", 32'(hit), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrun_reset_wren", 32'(wren), 32'd0);
        chk("midrun_reset_done", 32'(done), 32'd0);
        chk("midrun_reset_busy", 32'(busy), 32'd0);
        chk("midrun_reset_address", 32'(address), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("midrun_writes", 32'(wr_seen), 32'd5);
        exp_q.delete();

        run(32, 8'hA5, 1'b0, 1'b0);   // full run
        run(5, 8'h3C, 1'b0, 1'b0);    // partial
        run(300, 8'h5A, 1'b0, 1'b0);  // clamp to 32
        run(0, 8'h11, 1'b0, 1'b0);    // zero words
        run(32, 8'hC3, 1'b1, 1'b0);   // input changes after accept

        // Restart: hold start through done, then drop and raise again.
        run(7, 8'h77, 1'b0, 1'b1);
        seen = wr_seen;
        repeat (20) @(negedge clk);
        chk("hold_no_retrigger", 32'(wr_seen - seen), 32'd0);
        chk("hold_done_level", 32'(done), 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("idle_done_kept", 32'(done), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        run(9, 8'h0F, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
